// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use bubbles
// Define HAZARD_STATS_EN to add the saturating stallCount/fwdCount hazard counters.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               idValid,
    input  logic [ADDR_W-1:0]  idRs,
    input  logic [ADDR_W-1:0]  idRt,
    input  logic               idUsesRt,
    input  logic [ADDR_W-1:0]  idDest,
    input  logic [DATA_W-1:0]  idImm,
    input  logic               idRegWrite,
    input  logic               idMemRead,
    input  logic               idMemWrite,
    input  logic               idMemToReg,
    input  logic               idAluSrc,
    input  logic [ALUOP_W-1:0] idAluOp,
    input  logic [DATA_W-1:0]  dataA,
    input  logic [DATA_W-1:0]  dataB,
    input  logic               exMemRegWrite,
    input  logic [ADDR_W-1:0]  exMemDest,
    input  logic [DATA_W-1:0]  exMemResult,
    input  logic               memWbRegWrite,
    input  logic [ADDR_W-1:0]  memWbDest,
    input  logic [DATA_W-1:0]  memWbResult,
    input  logic               flush,
    input  logic               hold,
    output logic               stall,
`ifdef HAZARD_STATS_EN
    output logic [15:0]        stallCount,
    output logic [15:0]        fwdCount,
`endif
    output logic               exValid,
    output logic               exRegWrite,
    output logic               exMemRead,
    output logic               exMemWrite,
    output logic               exMemToReg,
    output logic               exAluSrc,
    output logic [ALUOP_W-1:0] exAluOp,
    output logic [DATA_W-1:0]  exOpA,
    output logic [DATA_W-1:0]  exOpB,
    output logic [DATA_W-1:0]  exImm,
    output logic [ADDR_W-1:0]  exDest,
    output logic [ADDR_W-1:0]  exRt
);

    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              loadUse;

    // Register 0 is hardwired zero, so it must never pick up a forwarded value.
    always_comb begin
        opA = dataA;
        if (idRs == '0)
            opA = '0;
        else if (exMemRegWrite && exMemDest == idRs)
            opA = exMemResult;
        else if (memWbRegWrite && memWbDest == idRs)
            opA = memWbResult;
    end

    always_comb begin
        opB = dataB;
        if (idRt == '0)
            opB = '0;
        else if (exMemRegWrite && exMemDest == idRt)
            opB = exMemResult;
        else if (memWbRegWrite && memWbDest == idRt)
            opB = memWbResult;
    end

    assign loadUse = idValid & exValid & exMemRead & (exDest != '0) &
                     ((exDest == idRs) | (idUsesRt & (exDest == idRt)));

    assign stall = ~rst & (hold | (loadUse & ~flush));

    // Every bubble clears operands too, so exRegWrite/exMemWrite can never leak past exValid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || (!hold && (loadUse || !idValid))) begin
            exValid    <= 1'b0;
            exRegWrite <= 1'b0;
            exMemRead  <= 1'b0;
            exMemWrite <= 1'b0;
            exMemToReg <= 1'b0;
            exAluSrc   <= 1'b0;
            exAluOp    <= '0;
            exOpA      <= '0;
            exOpB      <= '0;
            exImm      <= '0;
            exDest     <= '0;
            exRt       <= '0;
        end else if (!hold) begin
            exValid    <= 1'b1;
            exRegWrite <= idRegWrite;
            exMemRead  <= idMemRead;
            exMemWrite <= idMemWrite;
            exMemToReg <= idMemToReg;
            exAluSrc   <= idAluSrc;
            exAluOp    <= idAluOp;
            exOpA      <= opA;
            exOpB      <= opB;
            exImm      <= idImm;
            exDest     <= idDest;
            exRt       <= idRt;
        end
    end

`ifdef HAZARD_STATS_EN
    logic fwdA;
    logic fwdB;
    logic advance;

    assign fwdA = (idRs != '0) & ((exMemRegWrite & (exMemDest == idRs)) |
                                  (memWbRegWrite & (memWbDest == idRs)));
    assign fwdB = (idRt != '0) & ((exMemRegWrite & (exMemDest == idRt)) |
                                  (memWbRegWrite & (memWbDest == idRt)));
    assign advance = ~flush & ~hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= '0;
            fwdCount   <= '0;
        end else if (advance) begin
            if (loadUse && stallCount != 16'hFFFF)
                stallCount <= stallCount + 16'd1;
            if ((fwdA || fwdB) && fwdCount != 16'hFFFF)
                fwdCount <= fwdCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed self-checking bench for id_ex_stage
// Compiles the hazard counter checks when HAZARD_STATS_EN is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        idValid, idUsesRt;
    logic [4:0]  idRs, idRt, idDest;
    logic [31:0] idImm;
    logic        idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc;
    logic [3:0]  idAluOp;
    logic [31:0] dataA, dataB;
    logic        exMemRegWrite, memWbRegWrite;
    logic [4:0]  exMemDest, memWbDest;
    logic [31:0] exMemResult, memWbResult;
    logic        flush, hold;
    logic        stall;
    logic        exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc;
    logic [3:0]  exAluOp;
    logic [31:0] exOpA, exOpB, exImm;
    logic [4:0]  exDest, exRt;
`ifdef HAZARD_STATS_EN
    logic [15:0] stallCount, fwdCount;
    logic [15:0] m_sc, m_fc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .idDest(idDest), .idImm(idImm),
        .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idMemWrite(idMemWrite),
        .idMemToReg(idMemToReg), .idAluSrc(idAluSrc), .idAluOp(idAluOp),
        .dataA(dataA), .dataB(dataB),
        .exMemRegWrite(exMemRegWrite), .exMemDest(exMemDest), .exMemResult(exMemResult),
        .memWbRegWrite(memWbRegWrite), .memWbDest(memWbDest), .memWbResult(memWbResult),
        .flush(flush), .hold(hold), .stall(stall),
`ifdef HAZARD_STATS_EN
        .stallCount(stallCount), .fwdCount(fwdCount),
`endif
        .exValid(exValid), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .exMemWrite(exMemWrite), .exMemToReg(exMemToReg), .exAluSrc(exAluSrc),
        .exAluOp(exAluOp), .exOpA(exOpA), .exOpB(exOpB), .exImm(exImm),
        .exDest(exDest), .exRt(exRt)
    );

    typedef struct {
        logic        valid, rw, mr, mw, m2r, as;
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic [4:0]  dest, rt;
    } ex_t;

    ex_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return 32'h0;
        if (exMemRegWrite && exMemDest == r) return exMemResult;
        if (memWbRegWrite && memWbDest == r) return memWbResult;
        return rf;
    endfunction

    function automatic logic fwd_of(input logic [4:0] r);
        return r != 0 && ((exMemRegWrite && exMemDest == r) || (memWbRegWrite && memWbDest == r));
    endfunction

    function automatic logic m_load_use();
        return idValid && m.valid && m.mr && m.dest != 0 &&
               (m.dest == idRs || (idUsesRt && m.dest == idRt));
    endfunction

    function automatic logic exp_stall();
        return !rst && (hold || (m_load_use() && !flush));
    endfunction

    // Reference: what the ID/EX register must contain after each edge.
    always @(posedge clk or posedge rst) begin : model
        ex_t n;
        logic lu;
        lu = m_load_use();
        n = m;
        if (rst || flush || (!hold && (lu || !idValid))) begin
            n = '{default: '0};
        end else if (!hold) begin
            n.valid = 1'b1;  n.rw = idRegWrite; n.mr = idMemRead;  n.mw = idMemWrite;
            n.m2r = idMemToReg; n.as = idAluSrc; n.op = idAluOp;
            n.a = pick(idRs, dataA); n.b = pick(idRt, dataB);
            n.imm = idImm; n.dest = idDest; n.rt = idRt;
        end
        m <= n;
`ifdef HAZARD_STATS_EN
        if (rst) begin
            m_sc <= 16'h0;
            m_fc <= 16'h0;
        end else if (!flush && !hold) begin
            if (lu && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
            if ((fwd_of(idRs) || fwd_of(idRt)) && m_fc != 16'hFFFF) m_fc <= m_fc + 16'd1;
        end
`endif
    end

    always @(negedge clk) begin
        chk("exValid", {31'b0, exValid}, {31'b0, m.valid});
        chk("exRegWrite", {31'b0, exRegWrite}, {31'b0, m.rw});
        chk("exMemRead", {31'b0, exMemRead}, {31'b0, m.mr});
        chk("exMemWrite", {31'b0, exMemWrite}, {31'b0, m.mw});
        chk("exMemToReg", {31'b0, exMemToReg}, {31'b0, m.m2r});
        chk("exAluSrc", {31'b0, exAluSrc}, {31'b0, m.as});
        chk("exAluOp", {28'b0, exAluOp}, {28'b0, m.op});
        chk("exOpA", exOpA, m.a);
        chk("exOpB", exOpB, m.b);
        chk("exImm", exImm, m.imm);
        chk("exDest", {27'b0, exDest}, {27'b0, m.dest});
        chk("exRt", {27'b0, exRt}, {27'b0, m.rt});
        chk("stall", {31'b0, stall}, {31'b0, exp_stall()});
        if (!exValid) chk("bubble_writes", {31'b0, exRegWrite | exMemWrite}, 32'h0);
`ifdef HAZARD_STATS_EN
        chk("stallCount", {16'b0, stallCount}, {16'b0, m_sc});
        chk("fwdCount", {16'b0, fwdCount}, {16'b0, m_fc});
`endif
    end

    task automatic defaults();
        idValid = 0; idUsesRt = 0; idRs = 0; idRt = 0; idDest = 0; idImm = 0;
        idRegWrite = 0; idMemRead = 0; idMemWrite = 0; idMemToReg = 0; idAluSrc = 0;
        idAluOp = 0; dataA = 0; dataB = 0;
        exMemRegWrite = 0; exMemDest = 0; exMemResult = 0;
        memWbRegWrite = 0; memWbDest = 0; memWbResult = 0;
        flush = 0; hold = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_load_r3();
        defaults();
        idValid = 1; idMemRead = 1; idRegWrite = 1; idMemToReg = 1; idDest = 3; idRs = 1;
        tick();
    endtask

    initial begin
        rst = 1;
        defaults();
        tick(); tick();
        rst = 0;

        // EX/MEM beats MEM/WB and the register file
        idValid = 1; idRs = 5; exMemRegWrite = 1; exMemDest = 5; exMemResult = 32'h11;
        memWbRegWrite = 1; memWbDest = 5; memWbResult = 32'h22; dataA = 32'h33;
        tick();
        chk("t2_opA", exOpA, 32'h11);
        chk("t2_valid", {31'b0, exValid}, 32'h1);

        // MEM/WB forward on B, r0 on A ignores a matching EX/MEM
        defaults();
        idValid = 1; idRt = 7; memWbRegWrite = 1; memWbDest = 7; memWbResult = 32'hABCD;
        dataB = 32'h66; idRs = 0; exMemRegWrite = 1; exMemDest = 0; exMemResult = 32'hFF;
        dataA = 32'h55;
        tick();
        chk("t3_opB", exOpB, 32'hABCD);
        chk("t3_opA_r0", exOpA, 32'h0);

        // load-use bubble, then reissue with forward
        issue_load_r3();
        defaults();
        idValid = 1; idRs = 3; idDest = 4; dataA = 32'h99;
        #1 chk("t4_stall", {31'b0, stall}, 32'h1);
        tick();
        chk("t4_bubble_valid", {31'b0, exValid}, 32'h0);
        chk("t4_bubble_rw", {31'b0, exRegWrite}, 32'h0);
        exMemRegWrite = 1; exMemDest = 3; exMemResult = 32'h44;
        #1 chk("t4_stall_clear", {31'b0, stall}, 32'h0);
        tick();
        chk("t4_opA", exOpA, 32'h44);
        chk("t4_valid", {31'b0, exValid}, 32'h1);
`ifdef HAZARD_STATS_EN
        chk("t4_stallCount", {16'b0, stallCount}, 32'h1);
`endif

        // rt not a source: no hazard
        issue_load_r3();
        defaults();
        idValid = 1; idRt = 3; idRs = 1; idUsesRt = 0;
        #1 chk("t5_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("t5_valid", {31'b0, exValid}, 32'h1);

        // flush beats hold and load-use
        issue_load_r3();
        defaults();
        idValid = 1; idRs = 3; flush = 1; hold = 1;
        #1 chk("t6_stall", {31'b0, stall}, 32'h1);
        tick();
        chk("t6_flush_valid", {31'b0, exValid}, 32'h0);
        chk("t6_flush_mr", {31'b0, exMemRead}, 32'h0);
        defaults();
        idValid = 1; idImm = 32'h1234; idAluOp = 4'd5; idRegWrite = 1; idDest = 9;
        tick();
        hold = 1; idImm = 32'h9999; idAluOp = 4'd2; idDest = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_imm", exImm, 32'h1234);
            chk("t6_hold_op", {28'b0, exAluOp}, 32'h5);
            chk("t6_hold_valid", {31'b0, exValid}, 32'h1);
        end

        // async reset mid-cycle while holding a valid instruction
        #1 rst = 1;
        #1;
        chk("t1_valid", {31'b0, exValid}, 32'h0);
        chk("t1_imm", exImm, 32'h0);
        chk("t1_rw", {31'b0, exRegWrite}, 32'h0);
        chk("t1_stall", {31'b0, stall}, 32'h0);
        tick();
        rst = 0;
        hold = 0;

        for (int c = 0; c < 3000; c++) begin
            idValid       = ($urandom_range(0, 7) != 0);
            idRs          = 5'($urandom_range(0, 7));
            idRt          = 5'($urandom_range(0, 7));
            idUsesRt      = 1'($urandom);
            idDest        = 5'($urandom_range(0, 7));
            idImm         = $urandom;
            idRegWrite    = 1'($urandom);
            idMemRead     = 1'($urandom);
            idMemWrite    = 1'($urandom);
            idMemToReg    = 1'($urandom);
            idAluSrc      = 1'($urandom);
            idAluOp       = 4'($urandom);
            dataA         = $urandom;
            dataB         = $urandom;
            exMemRegWrite = 1'($urandom);
            exMemDest     = 5'($urandom_range(0, 7));
            exMemResult   = $urandom;
            memWbRegWrite = 1'($urandom);
            memWbDest     = 5'($urandom_range(0, 7));
            memWbResult   = $urandom;
            flush         = ($urandom_range(0, 9) == 0);
            hold          = ($urandom_range(0, 7) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage. It sits directly downstream of the register file's read ports (dataA/dataB).
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles.
- Registers the resolved operands and decoded control into the ID/EX pipeline register consumed by the ALU stage.

Parameters:
DATA_W, 32, operand/result width (matches register file data width)
ADDR_W, 5, register address width (32 architectural registers)
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous active-high reset
idValid  in  1  IF/ID holds a real instruction
idRs  in  ADDR_W  source A address (also drives register file addressA)
idRt  in  ADDR_W  source B address (also drives register file addressB)
idUsesRt  in  1  instruction reads rt as a source
idDest  in  ADDR_W  destination register
idImm  in  DATA_W  sign-extended immediate
idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc  in  1 each  decoded control
idAluOp  in  ALUOP_W  decoded ALU op
dataA, dataB  in  DATA_W  register file read data
exMemRegWrite  in  1  EX/MEM will write back
exMemDest  in  ADDR_W  EX/MEM destination
exMemResult  in  DATA_W  EX/MEM ALU result
memWbRegWrite  in  1  MEM/WB writing register file this cycle
memWbDest  in  ADDR_W  MEM/WB destination
memWbResult  in  DATA_W  MEM/WB write data
flush  in  1  squash instruction in ID (branch taken)
hold  in  1  downstream stall; freeze ID/EX
stall  out  1  combinational; freeze PC and IF/ID
exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc  out  1 each  registered
exAluOp  out  ALUOP_W  registered
exOpA, exOpB, exImm  out  DATA_W  registered operands/immediate
exDest, exRt  out  ADDR_W  registered destination and rt

Behaviour:
- Reset (async, rst=1): every registered output is 0 immediately. stall is 0 while rst=1.
- Latency: one cycle. ID values are visible on ex* outputs after the next rising edge.
- Operand resolution (combinational), shown for A using idRs; B is identical using idRt:
  - Address 0 yields 0. It is never forwarded and never reads the register file.
  - If exMemRegWrite and exMemDest==idRs, use exMemResult.
  - Else if memWbRegWrite and memWbDest==idRs, use memWbResult. This covers the register file's write-on-edge/read-combinational gap.
  - Else use dataA.
  - EX/MEM has priority over MEM/WB when both match.
- Load-use hazard: loadUse = idValid & exValid & exMemRead & exDest!=0 & (exDest==idRs | (idUsesRt & exDest==idRt)).
- stall = hold | (loadUse & ~flush).
- Edge update priority:
  1. flush: load a bubble, i.e. exValid=0 and all control outputs 0. Operand fields are don't-care; they are driven 0. Flush wins over hold.
  2. hold: all ex* registers keep their values.
  3. loadUse: load a bubble. The IF/ID instruction is retained by stall and reissued next cycle, when the forward comes from EX/MEM.
  4. idValid=0: load a bubble.
  5. Otherwise: load the resolved operands and all id* fields, with exValid=1.
- Bubble guarantees: exRegWrite and exMemWrite are never 1 with exValid=0.
- Reset mid-stall: all state clears; stall depends only on current inputs after reset release.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined, the block adds:
  - Output stallCount[15:0]: increments on each edge where loadUse caused a bubble.
  - Output fwdCount[15:0]: increments on each non-held, non-flushed edge where either operand used a forwarded value.
  - Both counters saturate at 16'hFFFF, are cleared by rst, and freeze during hold.
- Undefined: the ports and counters are absent, and functional behaviour is identical.

Test Plan:
1. Reset: assert rst mid-run with exValid=1 -> all ex* outputs 0 the same cycle; stall=0.
2. EX/MEM forward: idRs=5, exMemRegWrite=1, exMemDest=5, exMemResult=0x11, memWbDest=5, memWbResult=0x22, dataA=0x33 -> exOpA=0x11 next edge.
3. MEM/WB forward and zero register:
   - idRt=7, memWbRegWrite=1, memWbDest=7, memWbResult=0xABCD -> exOpB=0xABCD.
   - idRs=0 with exMemDest=0, exMemResult=0xFF -> exOpA=0.
4. Load-use: prior instruction lw into r3 (exMemRead=1, exDest=3), idRs=3 -> stall=1; next edge exValid=0, exRegWrite=0. Following cycle, with the forward from exMemResult=0x44 -> exOpA=0x44, exValid=1.
5. idUsesRt=0, idRt=3, same load -> stall=0, no bubble.
6. Priority: flush=1 with hold=1 and loadUse=1 -> bubble loaded, stall=1 (hold). hold=1 alone for 3 cycles -> ex* unchanged. With HAZARD_STATS_EN, after test 4, stallCount=1.
